// File: rtl/dcache_req_responder_pkg.sv
// dcache_req_responder_pkg: state, bus size and write-type encodings shared by the responder
package dcache_req_responder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [3:0] WT_BYTE = 4'b0001;
  localparam logic [3:0] WT_HALF = 4'b0011;
  localparam logic [3:0] WT_WORD = 4'b1111;
  function automatic logic [1:0] wt_size(input logic [3:0] wt);
    return wt == WT_WORD ? SZ_WORD : wt == WT_HALF ? SZ_HALF : SZ_BYTE;
  endfunction
endpackage

// File: rtl/dcache_req_responder_if.sv
// dcache_req_responder_if: pipeline request/response and SRAM-like bus signals of the responder
interface dcache_req_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [3:0]  req_write_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_is_atom;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  modport slave (
    input  req_valid, req_op, req_write_type, req_addr, req_wdata, req_is_atom,
    output req_ready, resp_valid, resp_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );
  modport master (
    output req_valid, req_op, req_write_type, req_addr, req_wdata, req_is_atom,
    input  req_ready, resp_valid, resp_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/dcache_req_responder_lane_align.sv
// dcache_req_responder_lane_align: store strobe/replication and load shift-and-mask by byte lane
module dcache_req_responder_lane_align
  import dcache_req_responder_pkg::*;
(
  input  logic        st_op_i,
  input  logic [3:0]  st_wt_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_wstrb_o,
  output logic [31:0] st_wdata_o,
  input  logic [3:0]  ld_wt_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);
  always_comb begin
    st_wstrb_o = st_op_i ? st_wt_i << st_off_i : 4'b0000;
    st_wdata_o = st_wt_i == WT_BYTE ? {4{st_wdata_i[7:0]}} :
                 st_wt_i == WT_HALF ? {2{st_wdata_i[15:0]}} : st_wdata_i;
    ld_data_o  = (ld_rdata_i >> {ld_off_i, 3'b000}) &
                 {{8{ld_wt_i[3]}}, {8{ld_wt_i[2]}}, {8{ld_wt_i[1]}}, {8{ld_wt_i[0]}}};
  end
endmodule

// File: rtl/dcache_req_responder.sv
// dcache_req_responder: one-at-a-time load/store responder with LL/SC, turning pipeline requests into bus transactions
module dcache_req_responder
  import dcache_req_responder_pkg::*;
(
  input  logic clk,
  input  logic aresetn,
  input  logic flush_i,
  input  logic llbit_clear_i,
  output logic llbit_o,
  dcache_req_responder_if.slave dc
);
  state_e      state_q;
  logic        llbit_q, cancel_q, op_q, atom_q, bus_req_q, bus_wr_q, resp_valid_q;
  logic [3:0]  wt_q, bus_wstrb_q;
  logic [1:0]  bus_size_q;
  logic [31:0] bus_addr_q, bus_wdata_q, resp_rdata_q;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata, ld_data;
  logic        accept, sc_fail;
  assign accept  = dc.req_valid & dc.req_ready & ~flush_i;
  assign sc_fail = dc.req_op & dc.req_is_atom & ~llbit_q;
  dcache_req_responder_lane_align u_align (
    .st_op_i   (dc.req_op),
    .st_wt_i   (dc.req_write_type),
    .st_off_i  (dc.req_addr[1:0]),
    .st_wdata_i(dc.req_wdata),
    .st_wstrb_o(st_wstrb),
    .st_wdata_o(st_wdata),
    .ld_wt_i   (wt_q),
    .ld_off_i  (bus_addr_q[1:0]),
    .ld_rdata_i(dc.bus_rdata),
    .ld_data_o (ld_data)
  );
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      llbit_q      <= 1'b0;
      cancel_q     <= 1'b0;
      op_q         <= 1'b0;
      atom_q       <= 1'b0;
      wt_q         <= 4'b0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= 2'b0;
      bus_addr_q   <= 32'b0;
      bus_wstrb_q  <= 4'b0;
      bus_wdata_q  <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          op_q        <= dc.req_op;
          atom_q      <= dc.req_is_atom;
          wt_q        <= dc.req_write_type;
          bus_wr_q    <= dc.req_op;
          bus_size_q  <= wt_size(dc.req_write_type);
          bus_addr_q  <= dc.req_addr;
          bus_wstrb_q <= st_wstrb;
          bus_wdata_q <= st_wdata;
          if (dc.req_op & dc.req_is_atom) llbit_q <= 1'b0;
          if (sc_fail) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= 32'b0;
          end else begin
            state_q   <= S_REQ;
            bus_req_q <= 1'b1;
          end
        end
        S_REQ: if (dc.bus_addr_ok) begin
          state_q   <= S_WAIT;
          bus_req_q <= 1'b0;
          cancel_q  <= flush_i;
        end else if (flush_i) begin
          state_q   <= S_IDLE;
          bus_req_q <= 1'b0;
        end
        // A cancelled transaction still owes the bus its data_ok before we go idle
        S_WAIT: if (dc.bus_data_ok) begin
          cancel_q <= 1'b0;
          if (cancel_q | flush_i) state_q <= S_IDLE;
          else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= op_q ? {31'b0, atom_q} : ld_data;
          end
        end else if (flush_i) cancel_q <= 1'b1;
        S_RESP: begin
          state_q <= S_IDLE;
          if (!flush_i & !op_q & atom_q) llbit_q <= 1'b1;
        end
      endcase
      if (llbit_clear_i) llbit_q <= 1'b0;
    end
  end
  assign dc.req_ready  = state_q == S_IDLE;
  assign dc.resp_valid = resp_valid_q & ~flush_i;
  assign dc.resp_rdata = resp_rdata_q;
  assign dc.bus_req    = bus_req_q;
  assign dc.bus_wr     = bus_wr_q;
  assign dc.bus_size   = bus_size_q;
  assign dc.bus_addr   = bus_addr_q;
  assign dc.bus_wstrb  = bus_wstrb_q;
  assign dc.bus_wdata  = bus_wdata_q;
  assign llbit_o       = llbit_q;
endmodule
